branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor: BTB plus 2-bit saturating pattern history table (PHT).
- Predicts next-PC source and target for the fetch PC in the same cycle.
- Trained by the decode-stage branch-resolution commit record (bp_result_t: pc, pcsrc, target_pc), so it is the consumer end of decode's resolution interface.
- Its predict_pcsrc travels down the pipe registers and is compared at decode to produce bp_hit.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/pipes_pkg.sv | 18 +
 rtl/bp_pht.sv | 60 ++++++
 rtl/branch_predictor.sv | 93 +++++++++
 tb/tb_branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Branch predictor types, counter constants and PC index/tag helpers.
// Tags are stored zero-extended to BP_TAG_MAX_W so TAG_W can vary per instance.
package bp_pkg;

    localparam int BP_TAG_MAX_W = 32;

    typedef logic [1:0] counter_t;

    localparam counter_t STRONG_NT = 2'b00;
    localparam counter_t WEAK_NT   = 2'b01;
    localparam counter_t WEAK_T    = 2'b10;
    localparam counter_t STRONG_T  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_MAX_W-1:0] tag;
        logic [63:0]             target;
    } btb_entry_t;

    // Word index: pc[idx_w+1:2]
    function automatic logic [31:0] bp_idx(input logic [63:0] pc, input int idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    // Tag: pc[tag_w+idx_w+1:idx_w+2], zero-extended
    function automatic logic [BP_TAG_MAX_W-1:0] bp_tag(input logic [63:0] pc,
                                                       input int idx_w,
                                                       input int tag_w);
        return BP_TAG_MAX_W'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
    endfunction

    function automatic counter_t ctr_next(input counter_t c, input logic taken);
        if (taken) return (c == STRONG_T)  ? c : c + 2'd1;
        else       return (c == STRONG_NT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-wide types shared by fetch and decode: addresses, next-PC source
// and the decode-stage branch-resolution record consumed by the predictor.
package pipes_pkg;

    typedef logic [63:0] addr_t;

    typedef enum logic {
        PCPLUS4 = 1'b0,
        PCJUMP  = 1'b1
    } pcsrc_t;

    typedef struct packed {
        addr_t  pc;
        pcsrc_t pcsrc;
        addr_t  target_pc;
    } bp_result_t;

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of 2-bit saturating counters.
// Define BP_GSHARE_EN to hash the index with a global history register (gshare).
module bp_pht
    import bp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    counter_t         pht_q [DEPTH];
    counter_t         pht_d [DEPTH];
    logic [IDX_W-1:0] lookup_pidx;
    logic [IDX_W-1:0] upd_pidx;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    // Update hashes with the pre-shift history, matching what lookup saw.
    assign lookup_pidx = lookup_idx ^ ghr_q;
    assign upd_pidx    = upd_idx ^ ghr_q;
`else
    assign lookup_pidx = lookup_idx;
    assign upd_pidx    = upd_idx;
`endif

    always_comb begin
        pht_d = pht_q;
        if (upd_valid) pht_d[upd_pidx] = ctr_next(pht_q[upd_pidx], upd_taken);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pht_q[i] <= WEAK_NT;
        end else begin
            pht_q <= pht_d;
        end
    end

    assign lookup_taken = pht_q[lookup_pidx][1];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB + 2-bit PHT predictor, trained by decode's resolution record.
// Optional gshare indexing of the PHT via BP_GSHARE_EN (see bp_pht).
module branch_predictor
    import pipes_pkg::*;
    import bp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  addr_t       pc_f,
    output pcsrc_t      predict_pcsrc,
    output addr_t       predict_pc,
    input  logic        update_valid,
    input  bp_result_t  update,
    input  logic        update_hit,
    output logic [31:0] mispredict_cnt
);

    logic [IDX_W-1:0]        idx_f;
    logic [IDX_W-1:0]        idx_u;
    logic [BP_TAG_MAX_W-1:0] tag_f;
    logic [BP_TAG_MAX_W-1:0] tag_u;

    assign idx_f = IDX_W'(bp_idx(pc_f, IDX_W));
    assign idx_u = IDX_W'(bp_idx(update.pc, IDX_W));
    assign tag_f = bp_tag(pc_f, IDX_W, TAG_W);
    assign tag_u = bp_tag(update.pc, IDX_W, TAG_W);

    btb_entry_t  btb_q [DEPTH];
    btb_entry_t  btb_d [DEPTH];
    logic [31:0] mispredict_cnt_q;
    logic [31:0] mispredict_cnt_d;
    btb_entry_t  entry_f;
    logic        btb_hit;
    logic        pht_taken;
    logic        upd_taken;

    assign upd_taken = (update.pcsrc == PCJUMP);

    bp_pht #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pht (
        .clk          (clk),
        .reset        (reset),
        .lookup_idx   (idx_f),
        .lookup_taken (pht_taken),
        .upd_valid    (update_valid),
        .upd_idx      (idx_u),
        .upd_taken    (upd_taken)
    );

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign entry_f = btb_q[idx_f];
    assign btb_hit = entry_f.valid && (entry_f.tag == tag_f);

    always_comb begin
        predict_pcsrc = PCPLUS4;
        predict_pc    = pc_f + 64'd4;
        if (btb_hit && pht_taken) begin
            predict_pcsrc = PCJUMP;
            predict_pc    = entry_f.target;
        end
    end

    // Taken branches always (re)allocate, refreshing JALR targets on a tag match.
    always_comb begin
        btb_d            = btb_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_valid) begin
            if (upd_taken) begin
                btb_d[idx_u] = '{valid: 1'b1, tag: tag_u, target: update.target_pc};
            end
            if (!update_hit) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) btb_q[i] <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            btb_q            <= btb_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, no gshare).
module tb_branch_predictor;
    import pipes_pkg::*;

    logic        clk;
    logic        reset;
    addr_t       pc_f;
    pcsrc_t      predict_pcsrc;
    addr_t       predict_pc;
    logic        update_valid;
    bp_result_t  update;
    logic        update_hit;
    logic [31:0] mispredict_cnt;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_cnt;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .pc_f           (pc_f),
        .predict_pcsrc  (predict_pcsrc),
        .predict_pc     (predict_pc),
        .update_valid   (update_valid),
        .update         (update),
        .update_hit     (update_hit),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_update(input addr_t pc, input pcsrc_t src, input addr_t tgt,
                                input logic hit);
        @(negedge clk);
        update_valid     = 1'b1;
        update.pc        = pc;
        update.pcsrc     = src;
        update.target_pc = tgt;
        update_hit       = hit;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        if (!hit) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic lookup(input addr_t pc);
        pc_f = pc;
        #1;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        update_valid = 1'b0;
        update       = '0;
        update_hit   = 1'b1;
        pc_f         = 64'h8000_0000;
        exp_cnt      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0004}) begin
            n_errors++;
            $display("FAIL reset_pred: got %0d/%h exp 0/80000004", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d exp 0", mispredict_cnt);
        end
        lookup(64'hFFFF_FFFF_FFFF_FFFC);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h0}) begin
            n_errors++;
            $display("FAIL pc_wrap: got %0d/%h exp 0/0", predict_pcsrc, predict_pc);
        end
    endtask

    task automatic test_train;
        drive_update(64'h8000_0010, PCJUMP, 64'h8000_0100, 1'b0);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0100}) begin
            n_errors++;
            $display("FAIL train_hit: got %0d/%h exp 1/80000100", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL train_cnt: got %0d exp 1", mispredict_cnt);
        end
    endtask

    task automatic test_saturation;
        // 10 -> 01: BTB hit but weakly not-taken
        drive_update(64'h8000_0010, PCPLUS4, 64'h0, 1'b1);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0014}) begin
            n_errors++;
            $display("FAIL sat_01: got %0d/%h exp 0/80000014", predict_pcsrc, predict_pc);
        end
        // 01 -> 00 -> 00 (floor), then one taken -> 01
        drive_update(64'h8000_0010, PCPLUS4, 64'h0, 1'b0);
        drive_update(64'h8000_0010, PCPLUS4, 64'h0, 1'b1);
        drive_update(64'h8000_0010, PCJUMP, 64'h8000_0100, 1'b0);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0014}) begin
            n_errors++;
            $display("FAIL sat_floor: got %0d/%h exp 0/80000014", predict_pcsrc, predict_pc);
        end
        // 01 -> 10 -> 11 -> 11 -> 11, then not-taken -> 10
        for (int i = 0; i < 4; i++) drive_update(64'h8000_0010, PCJUMP, 64'h8000_0100, 1'b1);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0100}) begin
            n_errors++;
            $display("FAIL sat_11: got %0d/%h exp 1/80000100", predict_pcsrc, predict_pc);
        end
        drive_update(64'h8000_0010, PCPLUS4, 64'h0, 1'b0);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0100}) begin
            n_errors++;
            $display("FAIL sat_ceiling: got %0d/%h exp 1/80000100", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL sat_cnt: got %0d exp %0d", mispredict_cnt, exp_cnt);
        end
    endtask

    task automatic test_alias;
        lookup(64'h8000_0110);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0114}) begin
            n_errors++;
            $display("FAIL alias_miss: got %0d/%h exp 0/80000114", predict_pcsrc, predict_pc);
        end
        drive_update(64'h8000_0110, PCJUMP, 64'h8000_0200, 1'b0);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0014}) begin
            n_errors++;
            $display("FAIL alias_evict: got %0d/%h exp 0/80000014", predict_pcsrc, predict_pc);
        end
        lookup(64'h8000_0110);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0200}) begin
            n_errors++;
            $display("FAIL alias_hit: got %0d/%h exp 1/80000200", predict_pcsrc, predict_pc);
        end
        // Tag match with new target must refresh the stored target
        drive_update(64'h8000_0110, PCJUMP, 64'h8000_0300, 1'b0);
        lookup(64'h8000_0110);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0300}) begin
            n_errors++;
            $display("FAIL jalr_refresh: got %0d/%h exp 1/80000300", predict_pcsrc, predict_pc);
        end
        // Not-taken record for the other alias must leave the BTB alone
        drive_update(64'h8000_0010, PCPLUS4, 64'h0, 1'b1);
        lookup(64'h8000_0110);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0300}) begin
            n_errors++;
            $display("FAIL no_alloc: got %0d/%h exp 1/80000300", predict_pcsrc, predict_pc);
        end
    endtask

    task automatic test_same_cycle;
        pc_f = 64'h8000_0110;
        @(negedge clk);
        update_valid     = 1'b1;
        update.pc        = 64'h8000_0110;
        update.pcsrc     = PCPLUS4;
        update.target_pc = 64'h0;
        update_hit       = 1'b0;
        #1;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0300}) begin
            n_errors++;
            $display("FAIL same_cycle_old: got %0d/%h exp 1/80000300", predict_pcsrc, predict_pc);
        end
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        exp_cnt      = exp_cnt + 32'd1;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0114}) begin
            n_errors++;
            $display("FAIL same_cycle_new: got %0d/%h exp 0/80000114", predict_pcsrc, predict_pc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0114}) begin
            n_errors++;
            $display("FAIL held_stable: got %0d/%h exp 0/80000114", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL same_cycle_cnt: got %0d exp %0d", mispredict_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset;
        drive_update(64'h8000_0010, PCJUMP, 64'h8000_0100, 1'b0);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0100}) begin
            n_errors++;
            $display("FAIL pre_reset: got %0d/%h exp 1/80000100", predict_pcsrc, predict_pc);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0014}) begin
            n_errors++;
            $display("FAIL async_reset_pred: got %0d/%h exp 0/80000014", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset_cnt: got %0d exp 0", mispredict_cnt);
        end
        // Update presented across an edge while reset is still high is dropped
        update_valid     = 1'b1;
        update.pc        = 64'h8000_0010;
        update.pcsrc     = PCJUMP;
        update.target_pc = 64'h8000_0100;
        update_hit       = 1'b0;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCPLUS4, 64'h8000_0014}) begin
            n_errors++;
            $display("FAIL post_reset_pred: got %0d/%h exp 0/80000014", predict_pcsrc, predict_pc);
        end
        n_checks++;
        if (mispredict_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL post_reset_cnt: got %0d exp 0", mispredict_cnt);
        end
        // One taken update from the reset value 01 must reach 10
        drive_update(64'h8000_0010, PCJUMP, 64'h8000_0100, 1'b1);
        lookup(64'h8000_0010);
        n_checks++;
        if ({predict_pcsrc, predict_pc} !== {PCJUMP, 64'h8000_0100}) begin
            n_errors++;
            $display("FAIL reset_weak_nt: got %0d/%h exp 1/80000100", predict_pcsrc, predict_pc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
